// File: rtl/mmio_ui_controller_pkg.sv
// mmio_ui_controller_pkg: register offsets, ctrl bit positions, segment table and sticky ready/overrun helper
package mmio_ui_controller_pkg;
  localparam int WIN_BYTES = 64;
  localparam int RDY_BIT = 0;
  localparam int OVR_BIT = 2;
  localparam logic [5:0] OFF_HEX   = 6'h00;
  localparam logic [5:0] OFF_LEDR  = 6'h04;
  localparam logic [5:0] OFF_KDATA = 6'h10;
  localparam logic [5:0] OFF_SDATA = 6'h14;
  localparam logic [5:0] OFF_KCTRL = 6'h18;
  localparam logic [5:0] OFF_SCTRL = 6'h1C;
`ifdef UI_TIMER_EN
  localparam logic [5:0] OFF_TCNT  = 6'h20;
  localparam logic [5:0] OFF_TLIM  = 6'h24;
  localparam logic [5:0] OFF_TCTRL = 6'h28;
`endif
  // Active-low segments, digit 0 in the low 7 bits, up to F at the top.
  localparam logic [111:0] SEG_TBL = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  // st = {overrun, ready}; an event beats both a ready-clearing load and an overrun clear.
  function automatic logic [1:0] sticky(input logic [1:0] st, input logic ev, input logic clr_rdy,
                                        input logic clr_ovr);
    return {(ev & st[0] & ~clr_rdy) | (st[1] & ~clr_ovr), ev | (st[0] & ~clr_rdy)};
  endfunction
  function automatic logic [2:0] ctrl_bits(input logic [1:0] st);
    logic [2:0] c;
    c = '0;
    c[RDY_BIT] = st[0];
    c[OVR_BIT] = st[1];
    return c;
  endfunction
endpackage

// File: rtl/mmio_ui_controller_sev_seg_dec.sv
// mmio_ui_controller_sev_seg_dec: hex nibble to active-low seven-segment pattern
module mmio_ui_controller_sev_seg_dec
  import mmio_ui_controller_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TBL[7*nib +: 7];
endmodule

// File: rtl/mmio_ui_controller.sv
// mmio_ui_controller: memory-mapped HEX/LEDR/KEY/SW peripheral with sticky key/switch events; timer under UI_TIMER_EN
module mmio_ui_controller
  import mmio_ui_controller_pkg::*;
#(
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] BASE_ADDR = DBITS'(32'hF000_0000),
  parameter int NUM_HEX = 4,
  parameter int NUM_LEDR = 10,
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DBITS-1:0]     addr,
  input  logic [DBITS-1:0]     wdata,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic                 hit,
  output logic [DBITS-1:0]     rdata,
  input  logic [NUM_KEYS-1:0]  key,
  input  logic [NUM_SW-1:0]    sw,
  output logic [NUM_LEDR-1:0]  ledr,
  output logic [7*NUM_HEX-1:0] hex
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [DBITS-1:0] off, tmr_rdata;
  logic [5:0] a;
  logic wr, rd, sev, unused_ok;
  logic [4*NUM_HEX-1:0] hex_q, hex_d;
  logic [NUM_LEDR-1:0] ledr_q, ledr_d;
  logic [NUM_KEYS-1:0] ks1_q, ks1_d, ks2_q, ks2_d;
  logic [NUM_SW-1:0] ss1_q, ss1_d, ss2_q, ss2_d, sdata_q, sdata_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [1:0] kst_q, kst_d, sst_q, sst_d;
  assign off = addr - BASE_ADDR;
  assign hit = off < DBITS'(WIN_BYTES);
  assign a = off[5:0];
  assign wr = wr_en & hit;
  assign rd = rd_en & hit;
  assign ledr = ledr_q;
  assign unused_ok = ^wdata ^ (TICK_CYCLES == 0);
  // Synchronisers carry the pressed (inverted) key level so reset means "nothing pressed".
  always_comb begin
    hex_d = (wr && a == OFF_HEX) ? wdata[4*NUM_HEX-1:0] : hex_q;
    ledr_d = (wr && a == OFF_LEDR) ? wdata[NUM_LEDR-1:0] : ledr_q;
    ks1_d = ~key;
    ks2_d = ks1_q;
    ss1_d = sw;
    ss2_d = ss1_q;
    kst_d = sticky(kst_q, ks1_q != ks2_q, rd && a == OFF_KDATA, wr && a == OFF_KCTRL && !wdata[OVR_BIT]);
    sdata_d = sdata_q;
    dcnt_d = '0;
    sev = 1'b0;
    if (ss2_q != sdata_q) begin
      if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        sdata_d = ss2_q;
        sev = 1'b1;
      end else if (ss1_q == ss2_q) dcnt_d = dcnt_q + 1'b1;
    end
    sst_d = sticky(sst_q, sev, rd && a == OFF_SDATA, wr && a == OFF_SCTRL && !wdata[OVR_BIT]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q <= '0;
      ledr_q <= '0;
      ks1_q <= '0;
      ks2_q <= '0;
      ss1_q <= '0;
      ss2_q <= '0;
      sdata_q <= '0;
      dcnt_q <= '0;
      kst_q <= '0;
      sst_q <= '0;
    end else begin
      hex_q <= hex_d;
      ledr_q <= ledr_d;
      ks1_q <= ks1_d;
      ks2_q <= ks2_d;
      ss1_q <= ss1_d;
      ss2_q <= ss2_d;
      sdata_q <= sdata_d;
      dcnt_q <= dcnt_d;
      kst_q <= kst_d;
      sst_q <= sst_d;
    end
  end
`ifdef UI_TIMER_EN
  localparam int PW = $clog2(TICK_CYCLES + 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q, tlim_d;
  logic [1:0] tst_q, tst_d;
  logic tick, tset, tev;
  // A TCNT store overrides the tick in the same cycle and restarts the prescaler.
  always_comb begin
    tset = wr && a == OFF_TCNT;
    tick = presc_q == PW'(TICK_CYCLES - 1);
    tev = !tset && tick && tlim_q != '0 && tcnt_q == tlim_q - 1'b1;
    presc_d = (tset || tick) ? '0 : presc_q + 1'b1;
    tcnt_d = tset ? wdata : tev ? '0 : (tick && tlim_q != '0) ? tcnt_q + 1'b1 : tcnt_q;
    tlim_d = (wr && a == OFF_TLIM) ? wdata : tlim_q;
    tst_d = sticky(tst_q, tev, rd && a == OFF_TCNT, wr && a == OFF_TCTRL && !wdata[OVR_BIT]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tcnt_q <= '0;
      tlim_q <= '0;
      tst_q <= '0;
    end else begin
      presc_q <= presc_d;
      tcnt_q <= tcnt_d;
      tlim_q <= tlim_d;
      tst_q <= tst_d;
    end
  end
  assign tmr_rdata = a == OFF_TCNT ? tcnt_q :
                     a == OFF_TLIM ? tlim_q :
                     a == OFF_TCTRL ? DBITS'(ctrl_bits(tst_q)) : '0;
`else
  assign tmr_rdata = '0;
`endif
  assign rdata = !hit ? '0 :
                 a == OFF_HEX ? DBITS'(hex_q) :
                 a == OFF_LEDR ? DBITS'(ledr_q) :
                 a == OFF_KDATA ? DBITS'(ks2_q) :
                 a == OFF_SDATA ? DBITS'(sdata_q) :
                 a == OFF_KCTRL ? DBITS'(ctrl_bits(kst_q)) :
                 a == OFF_SCTRL ? DBITS'(ctrl_bits(sst_q)) : tmr_rdata;
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    mmio_ui_controller_sev_seg_dec u_dec (.nib(hex_q[4*i +: 4]), .seg(hex[7*i +: 7]));
  end
endmodule

// File: tb/tb_mmio_ui_controller.sv
// tb_mmio_ui_controller: directed plus random bus/pin stimulus against a behavioural model; timer checks under UI_TIMER_EN
module tb_mmio_ui_controller;
  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int DEB = 8;
  localparam int TICK = 2;
  localparam logic [6:0] SEGS [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                       7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 1'b0;
  logic reset_n, wr_en, rd_en, hit;
  logic [31:0] addr, wdata, rdata, v;
  logic [3:0] key;
  logic [9:0] sw, ledr;
  logic [27:0] hex;
  int checks = 0, errors = 0;
  logic [15:0] m_hex;
  logic [9:0] m_ledr, m_spin1, m_sync, m_sdata;
  logic [3:0] m_kpin1, m_kdata;
  logic m_krdy, m_kovr, m_srdy, m_sovr, m_trdy, m_tovr;
  logic [31:0] m_tcnt, m_tlim;
  int m_run, m_pc;

  always #5 clk = ~clk;

  mmio_ui_controller #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
    .hit(hit), .rdata(rdata), .key(key), .sw(sw), .ledr(ledr), .hex(hex));

  function automatic logic [27:0] hex_exp(input logic [15:0] h);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = SEGS[h[4*i +: 4]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_ledr = '0; m_kpin1 = '0; m_kdata = '0; m_krdy = 0; m_kovr = 0;
    m_spin1 = '0; m_sync = '0; m_sdata = '0; m_run = 1; m_srdy = 0; m_sovr = 0;
    m_tcnt = '0; m_tlim = '0; m_pc = 0; m_trdy = 0; m_tovr = 0;
  endtask

  task automatic upd_sticky(inout logic rdy, inout logic ovr, input bit ev, input bit ld, input bit clr);
    if (clr) ovr = 0;
    if (ev && rdy && !ld) ovr = 1;
    if (ev) rdy = 1;
    else if (ld) rdy = 0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [5:0] o, input logic [31:0] d);
    addr = BASE + {26'b0, o}; rd_en = rd; wr_en = wr; wdata = d;
  endtask

  // Advance one clock edge: the model consumes the inputs present before the edge.
  task automatic tick();
    logic [5:0] o = addr[5:0];
    bit win = (addr - BASE) < 32'd64;
    bit rd = rd_en && win;
    bit wr = wr_en && win;
    bit kev = m_kpin1 != m_kdata;
    bit sev = 0;
    m_kdata = m_kpin1;
    m_kpin1 = ~key;
    upd_sticky(m_krdy, m_kovr, kev, rd && o == 6'h10, wr && o == 6'h18 && !wdata[2]);
    if (m_sync != m_sdata && m_run >= DEB) begin
      m_sdata = m_sync;
      sev = 1;
    end
    if (m_spin1 == m_sync) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else begin
      m_run = 1;
      m_sync = m_spin1;
    end
    m_spin1 = sw;
    upd_sticky(m_srdy, m_sovr, sev, rd && o == 6'h14, wr && o == 6'h1C && !wdata[2]);
    if (wr && o == 6'h00) m_hex = wdata[15:0];
    if (wr && o == 6'h04) m_ledr = wdata[9:0];
`ifdef UI_TIMER_EN
    begin
      bit tev = 0;
      if (wr && o == 6'h20) begin
        m_tcnt = wdata;
        m_pc = 0;
      end else if (m_pc == TICK - 1) begin
        m_pc = 0;
        if (m_tlim != 0) begin
          if (m_tcnt == m_tlim - 1) begin
            m_tcnt = 0;
            tev = 1;
          end else m_tcnt++;
        end
      end else m_pc++;
      upd_sticky(m_trdy, m_tovr, tev, rd && o == 6'h20, wr && o == 6'h28 && !wdata[2]);
      if (wr && o == 6'h24) m_tlim = wdata;
    end
`endif
    @(posedge clk);
    #1;
    rd_en = 0; wr_en = 0;
  endtask

  task automatic peek(input logic [5:0] o, output logic [31:0] r);
    drive(0, 0, o, '0);
    #1;
    r = rdata;
  endtask

  task automatic check_all(input string p);
    logic [31:0] r;
    peek(6'h10, r); chk({p, "_kdata"}, r, {28'b0, m_kdata});
    peek(6'h14, r); chk({p, "_sdata"}, r, {22'b0, m_sdata});
    peek(6'h18, r); chk({p, "_kctrl"}, r, {29'b0, m_kovr, 1'b0, m_krdy});
    peek(6'h1C, r); chk({p, "_sctrl"}, r, {29'b0, m_sovr, 1'b0, m_srdy});
    peek(6'h04, r); chk({p, "_ledr_reg"}, r, {22'b0, m_ledr});
    chk({p, "_ledr_pin"}, {22'b0, ledr}, {22'b0, m_ledr});
    chk({p, "_hex_pin"}, {4'b0, hex}, {4'b0, hex_exp(m_hex)});
`ifdef UI_TIMER_EN
    peek(6'h20, r); chk({p, "_tcnt"}, r, m_tcnt);
    peek(6'h28, r); chk({p, "_tctrl"}, r, {29'b0, m_tovr, 1'b0, m_trdy});
`endif
  endtask

  initial begin
    reset_n = 0; key = '1; sw = '0; addr = '0; wdata = '0; rd_en = 0; wr_en = 0;
    model_reset();
    #12;
    chk("rst_hex", {4'b0, hex}, {4'b0, {4{7'b1000000}}});
    chk("rst_ledr", {22'b0, ledr}, 32'h0);
    peek(6'h18, v); chk("rst_kctrl", v, 32'h0);
    peek(6'h1C, v); chk("rst_sctrl", v, 32'h0);
    peek(6'h10, v); chk("rst_kdata", v, 32'h0);
    @(negedge clk) reset_n = 1;
    #1;
    tick(); tick(); tick();
    check_all("post_reset");
    drive(0, 1, 6'h00, 32'hABCD_1234); tick();
    chk("hex_d0", {25'b0, hex[6:0]}, {25'b0, 7'b0011001});
    chk("hex_d3", {25'b0, hex[27:21]}, {25'b0, 7'b1111001});
    peek(6'h00, v); chk("hex_read", v, 32'h1234);
    drive(0, 1, 6'h04, 32'hFFFF_FFFF); tick();
    peek(6'h04, v); chk("ledr_read", v, 32'h3FF);
    drive(0, 1, 6'h10, 32'hFFFF_FFFF); tick();
    peek(6'h10, v); chk("ro_store", v, 32'h0);
    drive(0, 1, 6'h08, 32'h5555_5555); tick();
    peek(6'h08, v); chk("unmapped", v, 32'h0);
    addr = BASE + 32'h3C; #1; chk("hit_top", {31'b0, hit}, 32'h1);
    addr = BASE + 32'h40; #1; chk("hit_above", {31'b0, hit}, 32'h0); chk("rdata_miss", rdata, 32'h0);
    addr = BASE - 32'h4; #1; chk("hit_below", {31'b0, hit}, 32'h0);
    key = 4'b1110; tick(); tick();
    peek(6'h10, v); chk("key0_kdata", v, 32'h1);
    peek(6'h18, v); chk("key0_kctrl", v, 32'h1);
    key = 4'b1100; tick(); tick();
    peek(6'h18, v); chk("key_ovr_kctrl", v, 32'h5);
    drive(1, 0, 6'h10, '0); tick();
    peek(6'h18, v); chk("load_kctrl", v, 32'h4);
    drive(0, 1, 6'h18, 32'h1); tick();
    peek(6'h18, v); chk("clr_ovr_kctrl", v, 32'h0);
    key = 4'b1000; tick(); tick();
    key = 4'b0000; tick();
    drive(1, 0, 6'h10, '0); tick();
    peek(6'h18, v); chk("load_vs_event", v, 32'h1);
    drive(1, 0, 6'h10, '0); tick();
    check_all("keys");
    sw = 10'h001;
    repeat (5) tick();
    sw = 10'h000;
    repeat (12) tick();
    peek(6'h14, v); chk("glitch_sdata", v, 32'h0);
    peek(6'h1C, v); chk("glitch_sctrl", v, 32'h0);
    sw = 10'h003;
    repeat (9) tick();
    peek(6'h14, v); chk("deb_early", v, 32'h0);
    tick();
    peek(6'h14, v); chk("deb_sdata", v, 32'h3);
    peek(6'h1C, v); chk("deb_sctrl", v, 32'h1);
    check_all("debounce");
    for (int n = 0; n < 250; n++) begin
      int op = $urandom_range(0, 11);
      if (op <= 2) key[$urandom_range(0, 3)] ^= 1'b1;
      else if (op == 3) sw = 10'($urandom);
      else if (op == 4) drive(1, 0, 6'h10, '0);
      else if (op == 5) drive(1, 0, 6'h14, '0);
      else if (op == 6) drive($urandom_range(0, 1) == 1, 1, 6'h18, $urandom);
      else if (op == 7) drive(0, 1, 6'h1C, $urandom);
      else if (op == 8) drive(0, 1, 6'h00, $urandom);
      else if (op == 9) drive(1, 1, 6'h04, $urandom);
      else if (op == 10) drive(0, 1, 6'($urandom_range(8, 15)), $urandom);
      tick();
      check_all("rand");
    end
    drive(0, 1, 6'h04, 32'h3FF); tick();
    chk("pre_areset_ledr", {22'b0, ledr}, 32'h3FF);
    key = '1; sw = '0;
    #2 reset_n = 0;
    #1;
    chk("areset_ledr", {22'b0, ledr}, 32'h0);
    chk("areset_hex", {4'b0, hex}, {4'b0, {4{7'b1000000}}});
    peek(6'h18, v); chk("areset_kctrl", v, 32'h0);
    peek(6'h1C, v); chk("areset_sctrl", v, 32'h0);
`ifdef UI_TIMER_EN
    peek(6'h28, v); chk("areset_tctrl", v, 32'h0);
`endif
    model_reset();
    @(negedge clk) reset_n = 1;
    #1;
    tick(); tick(); tick();
    check_all("post_areset");
`ifdef UI_TIMER_EN
    drive(0, 1, 6'h24, 32'd3); tick();
    drive(0, 1, 6'h20, 32'd0); tick();
    for (int n = 0; n < 14; n++) begin
      tick();
      check_all("timer");
    end
    drive(1, 0, 6'h20, '0); tick();
    check_all("timer_load");
`else
    drive(0, 1, 6'h20, 32'hFFFF_FFFF); tick();
    peek(6'h20, v); chk("no_timer_tcnt", v, 32'h0);
    drive(0, 1, 6'h24, 32'h7); tick();
    peek(6'h24, v); chk("no_timer_tlim", v, 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
